control_unit: RTL and testbench

Hardwired control sequencer that sits directly upstream of the `DataPath` block. It drives every register-transfer strobe, the ALU `operation` code and the memory `Read` strobe, one control step per clock. It takes the instruction register contents back from the datapath and sequences fetch (T0–T2) followed by an opcode-dependent execute phase (T3–T6).

---
 rtl/cu_pkg.sv | 90 +++++++++
 rtl/control_unit_if.sv | 43 ++++
 rtl/control_unit_sel_decode.sv | 20 ++
 rtl/control_unit.sv | 167 ++++++++++++++++
 tb/tb_control_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the control_unit sequencer: state encoding,
// opcode and ALU code maps, IR field positions and opcode classification helpers.
package cu_pkg;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_HALT  = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_BIN     = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_UNARY   = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SHR  = 4'b0101;
    localparam logic [3:0] ALU_SHL  = 4'b0110;
    localparam logic [3:0] ALU_ROR  = 4'b0111;
    localparam logic [3:0] ALU_ROL  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_NEG  = 4'b1101;
    localparam logic [3:0] ALU_NOT  = 4'b1110;

    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    function automatic op_class_e classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_BIN;
            OP_MUL, OP_DIV:                 return CLS_MULDIV;
            OP_NEG, OP_NOT:                 return CLS_UNARY;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Strobe/IR bundle between control_unit (master) and the datapath (slave).
// The illegal_op signal exists only when CU_ILLEGAL_TRAP_EN is defined.
interface control_unit_if #(parameter int REG_COUNT = 16);

    logic [31:0]          IR;
    logic                 PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, In_Portout;
    logic                 MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic                 Zin_low, Zin_high, IncPC, Read;
    logic [REG_COUNT-1:0] reg_out;
    logic [REG_COUNT-1:0] reg_in;
    logic [3:0]           operation;
    logic                 Run;
`ifdef CU_ILLEGAL_TRAP_EN
    logic                 illegal_op;

    modport master (
        input  IR,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, In_Portout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read,
        output reg_out, reg_in, operation, Run, illegal_op
    );
    modport slave (
        output IR,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, In_Portout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read,
        input  reg_out, reg_in, operation, Run, illegal_op
    );
`else
    modport master (
        input  IR,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, In_Portout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read,
        output reg_out, reg_in, operation, Run
    );
    modport slave (
        output IR,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, In_Portout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read,
        input  reg_out, reg_in, operation, Run
    );
`endif

endinterface

// File: rtl/control_unit_sel_decode.sv
// 4-to-N one-hot register select decoder with enable.
module sel_decode #(
    parameter int N = 16
) (
    input  logic [3:0]   sel,
    input  logic         en,
    output logic [N-1:0] onehot
);

    // One-hot decode; encodings beyond N select nothing.
    always_comb begin
        onehot = '0;
        if (en && (32'(sel) < N)) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the DataPath block. Defining
// CU_ILLEGAL_TRAP_EN makes illegal opcodes halt and raise a sticky illegal_op.
module control_unit
    import cu_pkg::*;
#(
    parameter int REG_COUNT = 16
) (
    input logic            Clock,
    input logic            clear,
    control_unit_if.master bus
);

    state_e               state_q, state_d;
    op_class_e            cls_s;
    logic [3:0]           alu_s, ra_s, rb_s, rc_s;
    logic                 out_en_s, in_en_s;
    logic [3:0]           out_idx_s, in_idx_s;
    logic [REG_COUNT-1:0] reg_out_s, reg_in_s;

    assign cls_s = classify(bus.IR[IR_OP_LSB +: 5]);
    assign alu_s = alu_code(bus.IR[IR_OP_LSB +: 5]);
    assign ra_s  = bus.IR[IR_RA_LSB +: 4];
    assign rb_s  = bus.IR[IR_RB_LSB +: 4];
    assign rc_s  = bus.IR[IR_RC_LSB +: 4];

    // Next-state: fixed fetch, then a class-dependent execute length.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = ST_T2;
            ST_T2: begin
                case (cls_s)
                    CLS_BIN, CLS_MULDIV, CLS_UNARY: state_d = ST_T3;
                    CLS_HALT:                       state_d = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL:                    state_d = ST_HALT;
`endif
                    default:                        state_d = ST_T0;
                endcase
            end
            ST_T3:    state_d = ST_T4;
            ST_T4: begin
                if ((cls_s == CLS_BIN) || (cls_s == CLS_MULDIV)) begin
                    state_d = ST_T5;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T5: begin
                if (cls_s == CLS_MULDIV) begin
                    state_d = ST_T6;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T6:    state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
    end

    // State register; clear aborts any instruction immediately.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Sticky flag: set on an illegal opcode at decode, cleared only by clear.
    always_comb begin
        if ((state_q == ST_T2) && (cls_s == CLS_ILLEGAL)) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Illegal-opcode flag register.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegal_op = illegal_q;
`endif

    // Strobe decode from the state register; IR fields only matter from T3.
    always_comb begin
        bus.PCout = 1'b0;  bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
        bus.HIout = 1'b0;  bus.LOout = 1'b0;   bus.Cout = 1'b0;     bus.In_Portout = 1'b0;
        bus.MARin = 1'b0;  bus.PCin = 1'b0;    bus.MDRin = 1'b0;    bus.IRin = 1'b0;
        bus.Yin = 1'b0;    bus.HIin = 1'b0;    bus.LOin = 1'b0;     bus.Zin_low = 1'b0;
        bus.Zin_high = 1'b0; bus.IncPC = 1'b0; bus.Read = 1'b0;
        bus.operation = ALU_NONE;
        bus.Run = (state_q != ST_RESET) && (state_q != ST_HALT);
        out_en_s = 1'b0; out_idx_s = 4'd0;
        in_en_s  = 1'b0; in_idx_s  = 4'd0;
        case (state_q)
            ST_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin_low = 1'b1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            ST_T3: begin
                case (cls_s)
                    CLS_BIN:    begin out_en_s = 1'b1; out_idx_s = rb_s; bus.Yin = 1'b1; end
                    CLS_MULDIV: begin out_en_s = 1'b1; out_idx_s = ra_s; bus.Yin = 1'b1; end
                    CLS_UNARY: begin
                        out_en_s = 1'b1; out_idx_s = rb_s;
                        bus.operation = alu_s; bus.Zin_low = 1'b1;
                    end
                    default:    out_en_s = 1'b0;
                endcase
            end
            ST_T4: begin
                case (cls_s)
                    CLS_BIN: begin
                        out_en_s = 1'b1; out_idx_s = rc_s;
                        bus.operation = alu_s; bus.Zin_low = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_en_s = 1'b1; out_idx_s = rb_s; bus.operation = alu_s;
                        bus.Zin_low = 1'b1; bus.Zin_high = 1'b1;
                    end
                    CLS_UNARY:  begin bus.Zlowout = 1'b1; in_en_s = 1'b1; in_idx_s = ra_s; end
                    default:    out_en_s = 1'b0;
                endcase
            end
            ST_T5: begin
                case (cls_s)
                    CLS_BIN:    begin bus.Zlowout = 1'b1; in_en_s = 1'b1; in_idx_s = ra_s; end
                    CLS_MULDIV: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    default:    in_en_s = 1'b0;
                endcase
            end
            ST_T6: begin
                if (cls_s == CLS_MULDIV) begin
                    bus.Zhighout = 1'b1; bus.HIin = 1'b1;
                end else begin
                    bus.Zhighout = 1'b0;
                end
            end
            default: bus.Run = 1'b0;
        endcase
    end

    sel_decode #(.N(REG_COUNT)) u_out_dec (.sel(out_idx_s), .en(out_en_s), .onehot(reg_out_s));
    sel_decode #(.N(REG_COUNT)) u_in_dec  (.sel(in_idx_s),  .en(in_en_s),  .onehot(reg_in_s));

    assign bus.reg_out = reg_out_s;
    assign bus.reg_in  = reg_in_s;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a cycle-list reference model pushes the
// expected strobe set for every control step; a monitor pops and compares.
`timescale 1ns/1ps
module tb_control_unit;

    typedef struct packed {
        logic pcout, zlowout, zhighout, mdrout, hiout, loout, cout, inportout;
        logic marin, pcin, mdrin, irin, yin, hiin, loin, zin_low, zin_high, incpc, read;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [3:0]  op;
        logic        run;
        logic        ill;
    } obs_t;

    logic Clock = 1'b0;
    logic clear;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   instr_no = 0;
    bit   armed = 1'b0;
    obs_t  sb_q[$];
    string tag_q[$];
    logic [3:0] alu_tbl [logic [4:0]];

    control_unit_if #(.REG_COUNT(16)) bus ();
    control_unit #(.REG_COUNT(16)) dut (.Clock(Clock), .clear(clear), .bus(bus));

    always #5 Clock = ~Clock;

    function automatic obs_t sample();
        obs_t o;
        o = '0;
        o.pcout = bus.PCout;  o.zlowout = bus.Zlowout; o.zhighout = bus.Zhighout;
        o.mdrout = bus.MDRout; o.hiout = bus.HIout; o.loout = bus.LOout;
        o.cout = bus.Cout; o.inportout = bus.In_Portout;
        o.marin = bus.MARin; o.pcin = bus.PCin; o.mdrin = bus.MDRin; o.irin = bus.IRin;
        o.yin = bus.Yin; o.hiin = bus.HIin; o.loin = bus.LOin; o.zin_low = bus.Zin_low;
        o.zin_high = bus.Zin_high; o.incpc = bus.IncPC; o.read = bus.Read;
        o.rout = bus.reg_out; o.rin = bus.reg_in; o.op = bus.operation; o.run = bus.Run;
`ifdef CU_ILLEGAL_TRAP_EN
        o.ill = bus.illegal_op;
`endif
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected per-cycle strobes of one instruction, from T0.
    function automatic int push_instr(input logic [31:0] ir, input int limit);
        obs_t c[$];
        obs_t o;
        logic [4:0] op = ir[31:27];
        int ra = int'(ir[26:23]);
        int rb = int'(ir[22:19]);
        int rc = int'(ir[18:15]);
        int n;
        o = '0; o.run = 1'b1; o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zin_low = 1'b1;
        c.push_back(o);
        o = '0; o.run = 1'b1; o.zlowout = 1'b1; o.pcin = 1'b1; o.read = 1'b1; o.mdrin = 1'b1;
        c.push_back(o);
        o = '0; o.run = 1'b1; o.mdrout = 1'b1; o.irin = 1'b1;
        c.push_back(o);
        if (op == 5'b01111 || op == 5'b10000) begin
            o = '0; o.run = 1'b1; o.rout = 16'h0001 << ra; o.yin = 1'b1; c.push_back(o);
            o = '0; o.run = 1'b1; o.rout = 16'h0001 << rb; o.op = alu_tbl[op];
            o.zin_low = 1'b1; o.zin_high = 1'b1; c.push_back(o);
            o = '0; o.run = 1'b1; o.zlowout = 1'b1; o.loin = 1'b1; c.push_back(o);
            o = '0; o.run = 1'b1; o.zhighout = 1'b1; o.hiin = 1'b1; c.push_back(o);
        end else if (op == 5'b10001 || op == 5'b10010) begin
            o = '0; o.run = 1'b1; o.rout = 16'h0001 << rb; o.op = alu_tbl[op];
            o.zin_low = 1'b1; c.push_back(o);
            o = '0; o.run = 1'b1; o.zlowout = 1'b1; o.rin = 16'h0001 << ra; c.push_back(o);
        end else if (alu_tbl.exists(op)) begin
            o = '0; o.run = 1'b1; o.rout = 16'h0001 << rb; o.yin = 1'b1; c.push_back(o);
            o = '0; o.run = 1'b1; o.rout = 16'h0001 << rc; o.op = alu_tbl[op];
            o.zin_low = 1'b1; c.push_back(o);
            o = '0; o.run = 1'b1; o.zlowout = 1'b1; o.rin = 16'h0001 << ra; c.push_back(o);
        end
        n = (c.size() < limit) ? c.size() : limit;
        for (int k = 0; k < n; k++) begin
            sb_q.push_back(c[k]);
            tag_q.push_back($sformatf("i%0d_op%b_t%0d", instr_no, op, k));
        end
        instr_no++;
        return n;
    endfunction

    task automatic run_instr(input logic [31:0] ir);
        int n;
        n = push_instr(ir, 99);
        @(negedge Clock);
        bus.IR = ir;
        repeat (n - 1) @(negedge Clock);
    endtask

    task automatic push_idle(input int cycles, input logic ill);
        obs_t o;
        o = '0;
        o.ill = ill;
        for (int k = 0; k < cycles; k++) begin
            sb_q.push_back(o);
            tag_q.push_back($sformatf("halt_%0d", k));
        end
    endtask

    task automatic release_clear();
        clear = 1'b1;
        armed = 1'b1;
    endtask

    task automatic reset_pulse(input string name);
        armed = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
            tag_q.delete();
        end
        clear = 1'b0;
        #1 check({name, "_async"}, sample(), obs_t'(0));
        @(negedge Clock);
        check({name, "_held"}, sample(), obs_t'(0));
        release_clear();
    endtask

    // Monitor: one expected record consumed per control step while armed.
    always begin
        @(posedge Clock);
        #1;
        if (armed) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got output with no expected entry");
            end else begin
                check(tag_q.pop_front(), sample(), sb_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  legal_ops [13];
        logic [4:0]  op;
        logic [31:0] ir;
        int n;
        alu_tbl[5'b00011] = 4'b0011; alu_tbl[5'b00100] = 4'b0100;
        alu_tbl[5'b00101] = 4'b1001; alu_tbl[5'b00110] = 4'b1010;
        alu_tbl[5'b00111] = 4'b0101; alu_tbl[5'b01000] = 4'b0110;
        alu_tbl[5'b01001] = 4'b0111; alu_tbl[5'b01010] = 4'b1000;
        alu_tbl[5'b01111] = 4'b1011; alu_tbl[5'b10000] = 4'b1100;
        alu_tbl[5'b10001] = 4'b1101; alu_tbl[5'b10010] = 4'b1110;
        legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                      5'b01001, 5'b01010, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11010};

        clear  = 1'b0;
        bus.IR = 32'h28918000;
        repeat (2) @(negedge Clock);
        check("reset_state", sample(), obs_t'(0));

        release_clear();
        run_instr(32'h28918000);
        run_instr(32'h7A280000);
        run_instr(32'h93380000);
        run_instr(32'hD0000000);

        n = push_instr(32'hD8000000, 99);
        push_idle(20, 1'b0);
        @(negedge Clock);
        bus.IR = 32'hD8000000;
        repeat (n + 19) @(negedge Clock);
        reset_pulse("halt_clear");
        run_instr(32'h18918000);

        n = push_instr(32'h1A298000, 5);
        @(negedge Clock);
        bus.IR = 32'h1A298000;
        repeat (n - 1) @(negedge Clock);
        armed = 1'b0;
        clear = 1'b0;
        #1 check("abort_async", sample(), obs_t'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock);
            #1 check($sformatf("abort_hold_%0d", k), sample(), obs_t'(0));
        end
        @(negedge Clock);
        release_clear();

`ifdef CU_ILLEGAL_TRAP_EN
        n = push_instr(32'hF8000000, 99);
        push_idle(5, 1'b1);
        @(negedge Clock);
        bus.IR = 32'hF8000000;
        repeat (n + 4) @(negedge Clock);
        reset_pulse("illegal_clear");
`else
        run_instr(32'hF8000000);
`endif

        for (int i = 0; i < 40; i++) begin
            op = legal_ops[$urandom_range(0, 12)];
`ifndef CU_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                do op = 5'($urandom_range(0, 31));
                while (alu_tbl.exists(op) || op == 5'b11010 || op == 5'b11011);
            end
`endif
            ir = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
            run_instr(ir);
        end

        armed = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
